// File: rtl/pixel_dispatcher_if.sv
// Pixel offer bus between the dispatcher and its array of neuron cores:
// one-hot offer, per-neuron ready/busy and the broadcast pixel payload.
interface pixel_dispatcher_if #(
  parameter int WIDTH     = 32,
  parameter int N_NEURONS = 4
);
  logic [N_NEURONS-1:0]    pixel_valid;
  logic [N_NEURONS-1:0]    pixel_ready;
  logic [N_NEURONS-1:0]    neuron_busy;
  logic signed [WIDTH-1:0] c_re;
  logic signed [WIDTH-1:0] c_im;
  logic [15:0]             pixel_id;

  modport master (
    output pixel_valid, c_re, c_im, pixel_id,
    input  pixel_ready, neuron_busy
  );

  modport slave (
    input  pixel_valid, c_re, c_im, pixel_id,
    output pixel_ready, neuron_busy
  );
endinterface

// File: rtl/pixel_dispatcher.sv
// Raster-scan pixel dispatcher feeding N Mandelbrot neuron cores round-robin.
// Optional stall/frame cycle counters are built when PIXEL_DISPATCH_STATS_EN is defined.
module pixel_dispatcher #(
  parameter int WIDTH     = 32,
  parameter int FRAC      = 28,
  parameter int N_NEURONS = 4,
  parameter int H_RES     = 160,
  parameter int V_RES     = 120
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic signed [WIDTH-1:0] re_start,
  input  logic signed [WIDTH-1:0] im_start,
  input  logic signed [WIDTH-1:0] step,
  pixel_dispatcher_if.master      pix,
  output logic                    running,
  output logic                    frame_done
`ifdef PIXEL_DISPATCH_STATS_EN
  ,
  output logic [31:0]             stall_cycles,
  output logic [31:0]             frame_cycles
`endif
);

  localparam int IDX_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
  localparam int X_W   = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int Y_W   = (V_RES > 1) ? $clog2(V_RES) : 1;

  localparam logic [X_W-1:0]       X_LAST   = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0]       Y_LAST   = Y_W'(V_RES - 1);
  localparam logic [N_NEURONS-1:0] ONE_HOT0 = N_NEURONS'(1);

  generate
    if (N_NEURONS < 1 || N_NEURONS > 16) begin : g_bad_neurons
      $error("pixel_dispatcher: N_NEURONS must be 1..16");
    end
    if (H_RES * V_RES > 65536 || H_RES < 1 || V_RES < 1) begin : g_bad_frame
      $error("pixel_dispatcher: frame must hold 1..65536 pixels");
    end
    if (FRAC >= WIDTH) begin : g_bad_frac
      $error("pixel_dispatcher: FRAC must be below WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t                  state;
  logic [X_W-1:0]          x;
  logic [Y_W-1:0]          y;
  logic [IDX_W-1:0]        rr;
  logic signed [WIDTH-1:0] re_lat;
  logic signed [WIDTH-1:0] step_lat;

  logic [IDX_W-1:0]        grant;
  logic                    any_ready;
  logic [N_NEURONS-1:0]    offer;
  logic                    xfer;
  logic                    start_ok;

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_NEURONS) s = s - N_NEURONS;
    return IDX_W'(s);
  endfunction

  // Coordinates wrap modulo 2^WIDTH on purpose; no saturation.
  function automatic logic signed [WIDTH-1:0] coord_add(input logic signed [WIDTH-1:0] a,
                                                        input logic signed [WIDTH-1:0] b);
    return a + b;
  endfunction

  function automatic logic signed [WIDTH-1:0] coord_sub(input logic signed [WIDTH-1:0] a,
                                                        input logic signed [WIDTH-1:0] b);
    return a - b;
  endfunction

  // Walk offsets from the highest down so the smallest offset from rr wins.
  always_comb begin
    grant     = '0;
    any_ready = 1'b0;
    for (int i = N_NEURONS - 1; i >= 0; i--) begin
      if (pix.pixel_ready[wrap_idx(rr, i)]) begin
        grant     = wrap_idx(rr, i);
        any_ready = 1'b1;
      end
    end
  end

  assign offer           = ONE_HOT0 << grant;
  assign pix.pixel_valid = (state == S_RUN && !abort && any_ready) ? offer : '0;
  assign xfer            = |(pix.pixel_valid & pix.pixel_ready);
  // A start landing on the frame_done cycle belongs to the finished frame and is dropped.
  assign start_ok        = (state == S_IDLE) && start && !abort && !frame_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      x            <= '0;
      y            <= '0;
      rr           <= '0;
      re_lat       <= '0;
      step_lat     <= '0;
      pix.c_re     <= '0;
      pix.c_im     <= '0;
      pix.pixel_id <= '0;
      running      <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            re_lat       <= re_start;
            step_lat     <= step;
            pix.c_re     <= re_start;
            pix.c_im     <= im_start;
            pix.pixel_id <= '0;
            x            <= '0;
            y            <= '0;
            running      <= 1'b1;
            state        <= S_RUN;
          end
        end
        S_RUN: begin
          if (abort) begin
            running <= 1'b0;
            state   <= S_IDLE;
          end else if (xfer) begin
            rr           <= wrap_idx(grant, 1);
            pix.pixel_id <= pix.pixel_id + 16'd1;
            if (x != X_LAST) begin
              x        <= x + 1'b1;
              pix.c_re <= coord_add(pix.c_re, step_lat);
            end else begin
              x        <= '0;
              y        <= y + 1'b1;
              pix.c_re <= re_lat;
              pix.c_im <= coord_sub(pix.c_im, step_lat);
              if (y == Y_LAST) state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (abort) begin
            running <= 1'b0;
            state   <= S_IDLE;
          end else if (pix.neuron_busy == '0) begin
            frame_done <= 1'b1;
            running    <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: begin
          running <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

`ifdef PIXEL_DISPATCH_STATS_EN
  logic cnt_on;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // frame_cycles includes the start cycle and the frame_done cycle, then holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      frame_cycles <= '0;
      cnt_on       <= 1'b0;
    end else if (start_ok) begin
      stall_cycles <= '0;
      frame_cycles <= 32'd1;
      cnt_on       <= 1'b1;
    end else begin
      if (state == S_RUN && !any_ready) stall_cycles <= sat_inc(stall_cycles);
      if (cnt_on) begin
        frame_cycles <= sat_inc(frame_cycles);
        if (frame_done || abort) cnt_on <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pixel_dispatcher.sv
// Directed bench for pixel_dispatcher on a 4x3 frame with four neurons.
module tb_pixel_dispatcher;
  localparam int W = 32;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [W-1:0]  re_start;
  logic [W-1:0]  im_start;
  logic [W-1:0]  step;
  logic          running;
  logic          frame_done;
`ifdef PIXEL_DISPATCH_STATS_EN
  logic [31:0]   stall_cycles;
  logic [31:0]   frame_cycles;
`endif

  int errors = 0;
  int checks = 0;

  pixel_dispatcher_if #(.WIDTH(W), .N_NEURONS(N)) pif ();

  pixel_dispatcher #(
    .WIDTH(W), .FRAC(28), .N_NEURONS(N), .H_RES(4), .V_RES(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .abort(abort),
    .re_start(re_start),
    .im_start(im_start),
    .step(step),
    .pix(pif),
    .running(running),
    .frame_done(frame_done)
`ifdef PIXEL_DISPATCH_STATS_EN
    ,
    .stall_cycles(stall_cycles),
    .frame_cycles(frame_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ready;
    logic [3:0]  vld;
    logic [15:0] id;
    logic [31:0] re;
    logic [31:0] im;
  } row_t;

  row_t        rows[29];
  logic [31:0] re_col[4];
  logic [31:0] im_row[3];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_row(input int i, input logic [3:0] rdy, input logic [3:0] vld,
                         input int id, input int col, input int rw);
    rows[i].ready = rdy;
    rows[i].vld   = vld;
    rows[i].id    = 16'(id);
    rows[i].re    = re_col[col];
    rows[i].im    = im_row[rw];
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      pif.pixel_ready = rows[i].ready;
      #1;
      check($sformatf("row%0d", i),
            128'({pif.pixel_valid, pif.pixel_id, pif.c_re, pif.c_im}),
            128'({rows[i].vld, rows[i].id, rows[i].re, rows[i].im}));
      @(negedge clk);
    end
  endtask

  task automatic start_frame();
    pif.pixel_ready = 4'b0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic expect_pix(input string name, input logic [15:0] id,
                            input logic [31:0] re, input logic [31:0] im);
    #1;
    check(name, 128'({pif.pixel_id, pif.c_re, pif.c_im}), 128'({id, re, im}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    re_col = '{32'hE000_0000, 32'hE800_0000, 32'hF000_0000, 32'hF800_0000};
    im_row = '{32'h1000_0000, 32'h0800_0000, 32'h0000_0000};
    for (int i = 0; i < 12; i++) set_row(i, 4'b1111, 4'(1 << (i % 4)), i, i % 4, i / 4);
    set_row(12, 4'b0100, 4'b0100, 0, 0, 0);
    set_row(13, 4'b0100, 4'b0100, 1, 1, 0);
    set_row(14, 4'b1001, 4'b1000, 2, 2, 0);
    set_row(15, 4'b1001, 4'b0001, 3, 3, 0);
    for (int i = 16; i <= 20; i++) set_row(i, 4'b0000, 4'b0000, 4, 0, 1);
    set_row(21, 4'b1111, 4'b0010, 4, 0, 1);
    set_row(22, 4'b1111, 4'b0100, 5, 1, 1);
    set_row(23, 4'b1111, 4'b1000, 6, 2, 1);
    set_row(24, 4'b1111, 4'b0001, 7, 3, 1);
    set_row(25, 4'b1111, 4'b0010, 8, 0, 2);
    set_row(26, 4'b1111, 4'b0100, 9, 1, 2);
    set_row(27, 4'b1111, 4'b1000, 10, 2, 2);
    set_row(28, 4'b1111, 4'b0001, 11, 3, 2);

    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    re_start = 32'hE000_0000;
    im_start = 32'h1000_0000;
    step     = 32'h0800_0000;
    pif.pixel_ready = 4'b1111;
    pif.neuron_busy = 4'b0000;
    #3;
    check("reset_outputs",
          128'({pif.pixel_valid, pif.pixel_id, pif.c_re, pif.c_im, running, frame_done}), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Frame 1: all ready, twelve back-to-back transfers.
    start_frame();
    run_rows(0, 11);
    pif.pixel_ready = 4'b0000;
    #1;
    check("drain1_state", 128'({pif.pixel_valid, running, frame_done}), 128'({4'b0000, 1'b1, 1'b0}));
    @(negedge clk);
    start = 1'b1;
    #1;
    check("done1_pulse", 128'({running, frame_done}), 128'({1'b0, 1'b1}));
    @(negedge clk);
    start = 1'b0;
    #1;
    check("start_on_done_ignored", 128'({running, frame_done}), 128'({1'b0, 1'b0}));

    // Frame 2: restricted readiness, rr from 3, five-cycle stall, then busy drain.
    @(negedge clk);
    start_frame();
    run_rows(12, 28);
    pif.pixel_ready = 4'b0000;
    pif.neuron_busy = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      #1;
      check($sformatf("drain_hold%0d", i), 128'({pif.pixel_valid, running, frame_done}),
            128'({4'b0000, 1'b1, 1'b0}));
      @(negedge clk);
    end
    pif.neuron_busy = 4'b0000;
    #1;
    check("drain_release", 128'({running, frame_done}), 128'({1'b1, 1'b0}));
    @(negedge clk);
    #1;
    check("done2_pulse", 128'({running, frame_done}), 128'({1'b0, 1'b1}));
`ifdef PIXEL_DISPATCH_STATS_EN
    check("stall_cycles", 128'(stall_cycles), 128'(5));
`endif
    @(negedge clk);
    #1;
    check("done2_single", 128'({running, frame_done}), 128'({1'b0, 1'b0}));
`ifdef PIXEL_DISPATCH_STATS_EN
    check("frame_cycles", 128'(frame_cycles), 128'(30));
`endif

    // Frame 3: abort at pixel 7.
    @(negedge clk);
    start_frame();
    pif.pixel_ready = 4'b1111;
    repeat (7) @(negedge clk);
    expect_pix("abort_at_id7", 16'd7, 32'hF800_0000, 32'h0800_0000);
    abort = 1'b1;
    #1;
    check("abort_valid_low", 128'(pif.pixel_valid), 128'(0));
    @(negedge clk);
    abort = 1'b0;
    #1;
    check("abort_idle", 128'({pif.pixel_valid, running, frame_done}), 128'({4'b0000, 1'b0, 1'b0}));
    @(negedge clk);
    #1;
    check("abort_no_done", 128'({pif.pixel_valid, running, frame_done}), 128'({4'b0000, 1'b0, 1'b0}));

    // Frame 4: wrap-around step, ignored start mid-frame, then async reset.
    @(negedge clk);
    re_start = 32'h0000_0000;
    im_start = 32'h0000_0000;
    step     = 32'h7FFF_FFFF;
    start_frame();
    pif.pixel_ready = 4'b1111;
    expect_pix("restart_id0", 16'd0, 32'h0000_0000, 32'h0000_0000);
    @(negedge clk);
    expect_pix("wrap_id1", 16'd1, 32'h7FFF_FFFF, 32'h0000_0000);
    start = 1'b1;
    re_start = 32'h1234_5678;
    @(negedge clk);
    start = 1'b0;
    expect_pix("wrap_id2", 16'd2, 32'hFFFF_FFFE, 32'h0000_0000);
    check("start_while_running", 128'(running), 128'(1));
    @(negedge clk);
    expect_pix("wrap_id3", 16'd3, 32'h7FFF_FFFD, 32'h0000_0000);
    @(negedge clk);
    expect_pix("wrap_id4", 16'd4, 32'h0000_0000, 32'h8000_0001);
    @(negedge clk);
    expect_pix("wrap_id5", 16'd5, 32'h7FFF_FFFF, 32'h8000_0001);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset",
          128'({pif.pixel_valid, pif.pixel_id, pif.c_re, pif.c_im, running, frame_done}), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // start and abort together while idle.
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    #1;
    check("start_abort_idle", 128'({pif.pixel_valid, running}), 128'({4'b0000, 1'b0}));
    @(negedge clk);
    #1;
    check("start_abort_stays", 128'({pif.pixel_valid, running}), 128'({4'b0000, 1'b0}));

    @(negedge clk);
    start_frame();
    pif.pixel_ready = 4'b1111;
    expect_pix("post_reset_start", 16'd0, 32'h1234_5678, 32'h0000_0000);
    check("post_reset_valid", 128'({pif.pixel_valid, running}), 128'({4'b0001, 1'b1}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
